config_stream_loader: RTL and testbench



---
 rtl/config_stream_loader_pkg.sv | 32 +++
 rtl/config_stream_loader_crc8_update.sv | 31 +++
 rtl/config_stream_loader.sv | 177 +++++++++++++++++
 tb/tb_config_stream_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_stream_loader_pkg.sv
// Shared definitions for the configuration stream loader: image sizing
// helpers (also used where the logic elements are instantiated), the
// loader state encoding and the CRC-8 polynomial.
// Optional build macro CONFIG_LOADER_CRC_EN adds a trailing CRC-8 word.
package config_stream_loader_pkg;

  // CRC-8 polynomial x^8 + x^2 + x + 1 (init value 0x00)
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } loader_state_e;

  // Config bits per element: LUT truth table (2^width) plus one register-select bit
  function automatic int conf_bits(input int width);
    return (1 << width) + 1;
  endfunction

  // Config bits for a whole column of elements
  function automatic int total_bits(input int width, input int num_elements);
    return num_elements * conf_bits(width);
  endfunction

  // Stream words needed to cover an image, last word possibly padded
  function automatic int num_words(input int bits, input int word_width);
    return (bits + word_width - 1) / word_width;
  endfunction

endpackage

// File: rtl/config_stream_loader_crc8_update.sv
// Combinational CRC-8 advance over one stream word, bits consumed from the
// MSB down to the LSB. Only instantiated when CONFIG_LOADER_CRC_EN is defined.
module config_crc8_update
  import config_stream_loader_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic [7:0]            crc_in,
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic [7:0]            crc_out
);

  logic [7:0] crc_work;
  logic       feedback;

  // Shift the word through the CRC one bit at a time, MSB first
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path leaves one unassigned and no latch is inferred.
    crc_work = crc_in;
    feedback = 1'b0;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      feedback = crc_work[7] ^ word_in[i];
      crc_work = {crc_work[6:0], 1'b0};
      if (feedback) begin
        crc_work = crc_work ^ CRC8_POLY;
      end
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/config_stream_loader.sv
// Configuration stream loader: collects a column's config image word by
// word into a shadow register and commits it to config_out in one cycle,
// so the logic elements never see a half-written image.
// Build macro CONFIG_LOADER_CRC_EN: expect one extra CRC-8 word after the
// data words and reject the image (error=1) on mismatch.
module config_stream_loader
  import config_stream_loader_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter int NUM_ELEMENTS = 4,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [WORD_WIDTH-1:0]                      word_in,
  input  logic                                       word_valid,
  output logic                                       word_ready,
  output logic [total_bits(WIDTH, NUM_ELEMENTS)-1:0] config_out,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       error
);

  localparam int TOTAL_BITS = total_bits(WIDTH, NUM_ELEMENTS);
  localparam int NUM_WORDS  = num_words(TOTAL_BITS, WORD_WIDTH);
  localparam int CNT_W      = $clog2(NUM_WORDS + 1);
  localparam int BIT_W      = $clog2(TOTAL_BITS);

  loader_state_e         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TOTAL_BITS-1:0] shadow_q, shadow_d;
  logic [TOTAL_BITS-1:0] config_q, config_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  int                    bit_idx;

`ifdef CONFIG_LOADER_CRC_EN
  logic [7:0] crc_q, crc_d, crc_next;
  logic       match_q, match_d;
  logic       error_q, error_d;

  config_crc8_update #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_crc (
    .crc_in (crc_q),
    .word_in(word_in),
    .crc_out(crc_next)
  );
`endif

  // Next-state, shadow fill and commit decisions
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    config_d   = config_q;
    busy_d     = busy_q;
    done_d     = done_q;
    word_ready = 1'b0;
    bit_idx    = 0;
`ifdef CONFIG_LOADER_CRC_EN
    crc_d      = crc_q;
    match_d    = match_q;
    error_d    = error_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
          crc_d   = '0;
          error_d = 1'b0;
`endif
        end
      end

      ST_LOAD: begin
        word_ready = 1'b1;
        if (word_valid) begin
          // Word k lands LSB first at bit k*WORD_WIDTH; pad bits past the image are dropped
          for (int j = 0; j < WORD_WIDTH; j++) begin
            bit_idx = int'(cnt_q) * WORD_WIDTH + j;
            if (bit_idx < TOTAL_BITS) begin
              shadow_d[BIT_W'(bit_idx)] = word_in[j];
            end
          end
`ifdef CONFIG_LOADER_CRC_EN
          if (cnt_q == CNT_W'(NUM_WORDS)) begin
            // Checksum word: counter stays at NUM_WORDS so it never overflows
            match_d = (word_in[7:0] == crc_q);
            state_d = ST_CHECK;
          end else begin
            crc_d = crc_next;
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
            state_d = ST_COMMIT;
          end
`endif
        end
      end

      ST_CHECK: begin
`ifdef CONFIG_LOADER_CRC_EN
        if (match_q) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_COMMIT: begin
        config_d = shadow_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here so every flop samples values from before the edge.
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      // NOTE: the shadow is plain flops, not a RAM, so it takes the reset and an aborted load leaves nothing behind.
      shadow_q <= '0;
      config_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
      crc_q    <= '0;
      match_q  <= 1'b0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      config_q <= config_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef CONFIG_LOADER_CRC_EN
      crc_q    <= crc_d;
      match_q  <= match_d;
      error_q  <= error_d;
`endif
    end
  end

  assign config_out = config_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef CONFIG_LOADER_CRC_EN
  assign error      = error_q;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_config_stream_loader.sv
// Self-checking bench for config_stream_loader (default parameters).
// Define CONFIG_LOADER_CRC_EN for both bench and RTL to cover the CRC build.
module tb_config_stream_loader;

  localparam int TOTAL  = 4 * ((1 << 6) + 1);  // 260
  localparam int NW     = (TOTAL + 7) / 8;     // 33
  localparam int BUDGET = 2000;

  logic             clock;
  logic             reset;
  logic             start;
  logic [7:0]       word_in;
  logic             word_valid;
  logic             word_ready;
  logic [TOTAL-1:0] config_out;
  logic             busy;
  logic             done;
  logic             error;

  int               checks;
  int               failures;
  logic [7:0]       words [NW+1];
  logic [TOTAL-1:0] committed;
  logic [TOTAL-1:0] exp_q [$];

  config_stream_loader #(
    .WIDTH       (6),
    .NUM_ELEMENTS(4),
    .WORD_WIDTH  (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .config_out(config_out),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_img(input string tag, input logic [TOTAL-1:0] obs, input logic [TOTAL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference packing: word k bit j -> image bit k*8+j, overflow bits dropped
  function automatic logic [TOTAL-1:0] build_image();
    logic [TOTAL-1:0] img;
    img = '0;
    for (int k = 0; k < NW; k++) begin
      for (int j = 0; j < 8; j++) begin
        if (k * 8 + j < TOTAL) img[k*8+j] = words[k][j];
      end
    end
    return img;
  endfunction

`ifdef CONFIG_LOADER_CRC_EN
  // Reference CRC-8 (poly 0x07, init 0) over all data words, MSB first
  function automatic logic [7:0] crc_of_words();
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < NW; k++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ words[k][i];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction
`endif

  // Drives one load from words[]; gap_pct = chance of an idle cycle,
  // abort_after != 0 resets the block after that many handshakes.
  task automatic run_load(input string tag, input int gap_pct, input bit pulse_start,
                          input int abort_after, input bit bad_crc);
    logic [TOTAL-1:0] img;
    logic [TOTAL-1:0] exp_img;
    int               k;
    int               n;
    int               cyc;
    bit               hs;
    bit               ok;
    n  = NW;
    ok = !bad_crc;
`ifdef CONFIG_LOADER_CRC_EN
    n = NW + 1;
    words[NW] = crc_of_words() ^ (bad_crc ? 8'h01 : 8'h00);
`endif
    img = build_image();
    if (ok) exp_q.push_back(img);

    // Idle: a valid word must be refused, start accepted
    word_valid = 1'b1;
    word_in    = 8'h5A;
    start      = 1'b1;
    check_bit({tag, "_idle_ready"}, word_ready, 1'b0);
    @(negedge clock);
    start = 1'b0;
    check_bit({tag, "_load_busy"}, busy, 1'b1);
    check_bit({tag, "_load_done"}, done, 1'b0);
    check_bit({tag, "_load_error"}, error, 1'b0);

    k   = 0;
    cyc = 0;
    while (k < n && cyc < BUDGET) begin
      if (abort_after != 0 && k == abort_after) break;
      word_valid = ($urandom_range(99) >= gap_pct);
      word_in    = word_valid ? words[k] : 8'($urandom);
      start      = pulse_start && (k == n / 2);
      check_bit({tag, "_ready_in_load"}, word_ready, 1'b1);
      check_img({tag, "_hold_prev"}, config_out, committed);
      hs = word_valid && word_ready;
      @(negedge clock);
      if (hs) k++;
      cyc++;
    end
    start = 1'b0;
    check_bit({tag, "_budget"}, cyc < BUDGET, 1'b1);

    if (abort_after != 0) begin
      word_valid = 1'b0;
      reset      = 1'b1;
      repeat (2) @(negedge clock);
      check_img({tag, "_rst_config"}, config_out, '0);
      check_bit({tag, "_rst_busy"}, busy, 1'b0);
      check_bit({tag, "_rst_done"}, done, 1'b0);
      check_bit({tag, "_rst_error"}, error, 1'b0);
      check_bit({tag, "_rst_ready"}, word_ready, 1'b0);
      reset = 1'b0;
      if (ok) void'(exp_q.pop_back());
      committed = '0;
      @(negedge clock);
      return;
    end

    // Keep junk valid on the bus: nothing more may be accepted
    word_valid = 1'b1;
    word_in    = 8'hC3;
`ifdef CONFIG_LOADER_CRC_EN
    check_bit({tag, "_check_ready"}, word_ready, 1'b0);
    check_bit({tag, "_check_busy"}, busy, 1'b1);
    check_bit({tag, "_check_done"}, done, 1'b0);
    @(negedge clock);
    if (!ok) begin
      check_bit({tag, "_err_error"}, error, 1'b1);
      check_bit({tag, "_err_done"}, done, 1'b0);
      check_bit({tag, "_err_busy"}, busy, 1'b0);
      check_bit({tag, "_err_ready"}, word_ready, 1'b0);
      check_img({tag, "_err_config"}, config_out, committed);
      word_valid = 1'b0;
      @(negedge clock);
      return;
    end
`endif
    // Commit cycle: old image still visible
    check_bit({tag, "_commit_ready"}, word_ready, 1'b0);
    check_bit({tag, "_commit_busy"}, busy, 1'b1);
    check_bit({tag, "_commit_done"}, done, 1'b0);
    check_img({tag, "_commit_hold"}, config_out, committed);
    @(negedge clock);
    check_bit({tag, "_done"}, done, 1'b1);
    check_bit({tag, "_busy_clear"}, busy, 1'b0);
    check_bit({tag, "_after_ready"}, word_ready, 1'b0);
    check_bit({tag, "_after_error"}, error, 1'b0);
    check_bit({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      exp_img = exp_q.pop_front();
      check_img({tag, "_image"}, config_out, exp_img);
      committed = exp_img;
    end
    word_valid = 1'b0;
    @(negedge clock);
    check_bit({tag, "_done_level"}, done, 1'b1);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    committed  = '0;
    reset      = 1'b1;
    start      = 1'b0;
    word_valid = 1'b0;
    word_in    = 8'h00;
    for (int k = 0; k <= NW; k++) words[k] = 8'h00;

    // Reset state
    repeat (2) @(negedge clock);
    check_img("reset_config", config_out, '0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_error", error, 1'b0);
    check_bit("reset_ready", word_ready, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Basic back-to-back load: word k = k, last word 0xF5
    for (int k = 0; k < NW; k++) words[k] = 8'(k);
    words[NW-1] = 8'hF5;
    run_load("basic", 0, 1'b0, 0, 1'b0);
    check_byte("basic_byte0", config_out[7:0], 8'h00);
    check_byte("basic_byte1", config_out[15:8], 8'h01);
    check_byte("basic_byte31", config_out[255:248], 8'h1F);
    check_byte("basic_top_nibble", {4'h0, config_out[259:256]}, 8'h05);

    // Same image with random gaps and a start pulse mid-load
    run_load("backpressure", 50, 1'b1, 0, 1'b0);

    // Reset after 10 words, then a full 0xAA load
    for (int k = 0; k < NW; k++) words[k] = 8'hAA;
    run_load("abort", 0, 1'b0, 10, 1'b0);
    run_load("all_aa", 0, 1'b0, 0, 1'b0);
    check_byte("aa_top_nibble", {4'h0, config_out[259:256]}, 8'h0A);
    check_byte("aa_byte0", config_out[7:0], 8'hAA);

    // Atomic reload: zeros then ones
    for (int k = 0; k < NW; k++) words[k] = 8'h00;
    run_load("all_00", 0, 1'b0, 0, 1'b0);
    check_img("zeros_image", config_out, '0);
    for (int k = 0; k < NW; k++) words[k] = 8'hFF;
    run_load("all_ff", 25, 1'b0, 0, 1'b0);
    check_img("ones_image", config_out, {TOTAL{1'b1}});

`ifdef CONFIG_LOADER_CRC_EN
    // Good checksum commits, corrupted checksum is rejected
    for (int k = 0; k < NW; k++) words[k] = 8'((k * 37) ^ 8'h5C);
    run_load("crc_ok", 0, 1'b0, 0, 1'b0);
    for (int k = 0; k < NW; k++) words[k] = 8'h3C;
    run_load("crc_bad", 0, 1'b0, 0, 1'b1);
    check_bit("crc_bad_error_level", error, 1'b1);
`endif

    check_bit("sb_drained", exp_q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
